// File: rtl/pci_target_pkg.sv
// pci_target_pkg: shared constants for the PCI target-side sequencer.
//   - FSM state encodings (IDLE..TURN)
//   - PCI memory command codes on C/BE#
//   - default address-to-data-phase retry limit (PCI 16-clock rule)
package pci_target_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLAIM = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_XFER  = 3'd3;
  localparam logic [2:0] ST_STOPW = 3'd4;
  localparam logic [2:0] ST_TURN  = 3'd5;

  localparam logic [3:0] CMD_MEMRD = 4'b0110;
  localparam logic [3:0] CMD_MEMWR = 4'b0111;

  localparam int unsigned RETRY_LIMIT_DEF = 16;

  // True for the two commands this target claims.
  function automatic logic is_mem_cmd(input logic [3:0] cbe);
    return (cbe == CMD_MEMRD) || (cbe == CMD_MEMWR);
  endfunction

endpackage

// File: rtl/pci_target_seq.sv
// pci_target_seq: PCI target sequencer for the AmigaPCI bridge.
// Claims memory cycles hitting the Amiga window, forwards each as one local
// request, and drives DEVSEL#/TRDY#/STOP# plus AD latch/direction controls.
// Single data phase only: bursts are disconnected with data, a slow local
// side is retried after RETRY_LIMIT clocks.
//
// Ports:
//   CLK, RESET           clock, asynchronous active-high reset
//   FRAMEn, IRDYn        initiator handshake (synchronised externally)
//   AD_IN, CBEn          address/data and command/byte-enable inputs
//   DEVSELn, TRDYn,
//   STOPn, CTRL_OE       target control values and their output enable
//   AD_OE                drive AD with read data
//   ALATCH, ADLATCH      address / write-data capture pulses
//   LOC_REQ, LOC_WRITE,
//   LOC_BE, LOC_ACK      local-side request interface
//
// Optional macro PCI_TARGET_PAR_EN adds RD_DATA (in), PAR and PAR_OE (out):
// read-data parity driven one clock after each read transfer.
module pci_target_seq
  import pci_target_pkg::*;
#(
  parameter int unsigned           BAR_BITS    = 8,
  parameter logic [BAR_BITS-1:0]   BASE        = BAR_BITS'(8'h40),
  parameter int unsigned           RETRY_LIMIT = RETRY_LIMIT_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FRAMEn,
  input  logic        IRDYn,
  input  logic [31:0] AD_IN,
  input  logic [3:0]  CBEn,
  output logic        DEVSELn,
  output logic        TRDYn,
  output logic        STOPn,
  output logic        CTRL_OE,
  output logic        AD_OE,
  output logic        ALATCH,
  output logic        ADLATCH,
  output logic        LOC_REQ,
  output logic        LOC_WRITE,
  output logic [3:0]  LOC_BE,
  input  logic        LOC_ACK
`ifdef PCI_TARGET_PAR_EN
  ,
  input  logic [31:0] RD_DATA,
  output logic        PAR,
  output logic        PAR_OE
`endif
);

  localparam int unsigned CNT_W = $clog2(RETRY_LIMIT + 1);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             frame_q;
  logic             addr_phase;

  logic             devsel_nxt, trdy_nxt, stop_nxt, ctrl_oe_nxt, ad_oe_nxt;
  logic             alatch_nxt, adlatch_nxt, loc_req_nxt, loc_write_nxt;
  logic [3:0]       loc_be_nxt;
  logic             xfer_edge;

  // Address bits below the window compare are not used by the sequencer.
  logic unused_ad;
  assign unused_ad = ^AD_IN[31-BAR_BITS:0];

  // Falling FRAME# with a window hit and a memory command.
  assign addr_phase = !FRAMEn && frame_q &&
                      (AD_IN[31 -: BAR_BITS] == BASE) && is_mem_cmd(CBEn);

  // Data moves on an edge where both ready strobes are low.
  assign xfer_edge = (state == ST_XFER) && !IRDYn && !TRDYn;

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    devsel_nxt    = DEVSELn;
    trdy_nxt      = TRDYn;
    stop_nxt      = STOPn;
    ctrl_oe_nxt   = CTRL_OE;
    ad_oe_nxt     = AD_OE;
    alatch_nxt    = 1'b0;
    adlatch_nxt   = 1'b0;
    loc_req_nxt   = LOC_REQ;
    loc_write_nxt = LOC_WRITE;
    loc_be_nxt    = LOC_BE;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (addr_phase) begin
          alatch_nxt    = 1'b1;
          loc_write_nxt = CBEn[0];
          // Count is 1 after E0, so its value at edge Ek equals k.
          cnt_nxt       = CNT_W'(1);
          state_nxt     = ST_CLAIM;
        end
      end

      ST_CLAIM: begin
        devsel_nxt  = 1'b0;
        ctrl_oe_nxt = 1'b1;
        loc_req_nxt = 1'b1;
        loc_be_nxt  = ~CBEn;
        cnt_nxt     = cnt + CNT_W'(1);
        state_nxt   = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (LOC_ACK) begin
          // Ack beats the retry limit; a still-low FRAME# means burst,
          // so disconnect with data.
          loc_req_nxt = 1'b0;
          trdy_nxt    = 1'b0;
          ad_oe_nxt   = !LOC_WRITE;
          stop_nxt    = FRAMEn;
          state_nxt   = ST_XFER;
        end else if (cnt == CNT_W'(RETRY_LIMIT)) begin
          stop_nxt    = 1'b0;
          trdy_nxt    = 1'b1;
          loc_req_nxt = 1'b0;
          state_nxt   = ST_STOPW;
        end else if (FRAMEn && IRDYn) begin
          loc_req_nxt = 1'b0;
          devsel_nxt  = 1'b1;
          trdy_nxt    = 1'b1;
          stop_nxt    = 1'b1;
          state_nxt   = ST_TURN;
        end
      end

      ST_XFER: begin
        if (xfer_edge) begin
          adlatch_nxt = LOC_WRITE;
          trdy_nxt    = 1'b1;
          ad_oe_nxt   = 1'b0;
          if (FRAMEn) begin
            devsel_nxt = 1'b1;
            stop_nxt   = 1'b1;
            state_nxt  = ST_TURN;
          end else begin
            stop_nxt   = 1'b0;
            state_nxt  = ST_STOPW;
          end
        end
      end

      ST_STOPW: begin
        if (FRAMEn) begin
          devsel_nxt = 1'b1;
          trdy_nxt   = 1'b1;
          stop_nxt   = 1'b1;
          state_nxt  = ST_TURN;
        end
      end

      ST_TURN: begin
        // Controls were driven high on entry; release them now.
        ctrl_oe_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      frame_q   <= 1'b1;
      DEVSELn   <= 1'b1;
      TRDYn     <= 1'b1;
      STOPn     <= 1'b1;
      CTRL_OE   <= 1'b0;
      AD_OE     <= 1'b0;
      ALATCH    <= 1'b0;
      ADLATCH   <= 1'b0;
      LOC_REQ   <= 1'b0;
      LOC_WRITE <= 1'b0;
      LOC_BE    <= 4'h0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_q   <= FRAMEn;
      DEVSELn   <= devsel_nxt;
      TRDYn     <= trdy_nxt;
      STOPn     <= stop_nxt;
      CTRL_OE   <= ctrl_oe_nxt;
      AD_OE     <= ad_oe_nxt;
      ALATCH    <= alatch_nxt;
      ADLATCH   <= adlatch_nxt;
      LOC_REQ   <= loc_req_nxt;
      LOC_WRITE <= loc_write_nxt;
      LOC_BE    <= loc_be_nxt;
    end
  end

`ifdef PCI_TARGET_PAR_EN
  // Parity over read data and byte enables, one clock after the read transfer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PAR    <= 1'b0;
      PAR_OE <= 1'b0;
    end else if (xfer_edge && !LOC_WRITE) begin
      PAR    <= ^{RD_DATA, CBEn};
      PAR_OE <= 1'b1;
    end else begin
      PAR    <= 1'b0;
      PAR_OE <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/pci_target_seq.md
Name: pci_target_seq

Overview:
- PCI target-side sequencer for the AmigaPCI bridge: the responder to the bridge's own PCI initiator cycles.
- Claims PCI memory cycles addressed to the Amiga window and forwards each as a single local request to the 68040-side arbiter.
- Drives DEVSEL#/TRDY#/STOP# and the AD latch/direction controls.
- Single data phase per transaction. Bursts are disconnected with data. A slow local side causes a retry.

Parameters:
- BAR_BITS, 8: number of upper address bits compared for a hit (AD[31:32-BAR_BITS]).
- BASE, 8'h40: window base value compared against those bits.
- RETRY_LIMIT, 16: clocks from the address phase to the first data phase before a retry is issued (PCI 16-clock rule).

Ports:
- CLK  in  1  PCI clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FRAMEn  in  1  PCI FRAME#, synchronised externally.
- IRDYn  in  1  PCI IRDY#.
- AD_IN  in  32  AD bus input.
- CBEn  in  4  C/BE# bus.
- DEVSELn  out  1  DEVSEL# value.
- TRDYn  out  1  TRDY# value.
- STOPn  out  1  STOP# value.
- CTRL_OE  out  1  output enable for DEVSEL#/TRDY#/STOP#.
- AD_OE  out  1  drive AD with read data (bus direction control).
- ALATCH  out  1  one-clock pulse that captures the address.
- ADLATCH  out  1  one-clock pulse that captures write data / BE on a completed write.
- LOC_REQ  out  1  local access request.
- LOC_WRITE  out  1  1 = write, valid while LOC_REQ.
- LOC_BE  out  4  active-high byte enables, valid while LOC_REQ.
- LOC_ACK  in  1  local side done; read data is valid when sampled.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - DEVSELn/TRDYn/STOPn = 1.
  - CTRL_OE, AD_OE, ALATCH, ADLATCH, LOC_REQ, LOC_WRITE = 0; LOC_BE = 0.
  - State = IDLE; wait counter = 0.
- States: IDLE, CLAIM, WAIT, XFER, STOPW, TURN.
- IDLE:
  - Address phase = edge E0 where FRAMEn=0, previous FRAMEn=1, AD_IN[31:32-BAR_BITS]==BASE, and CBEn==4'b0110 (mem read) or 4'b0111 (mem write).
  - On a hit: ALATCH=1 for the clock after E0, LOC_WRITE=CBEn[0], go to CLAIM.
  - Any other command or address: no response.
- CLAIM (one clock, medium decode):
  - At E1: DEVSELn=0, CTRL_OE=1, LOC_REQ=1, LOC_BE=~CBEn sampled at E1.
  - Go to WAIT.
- WAIT:
  - Counter increments each clock from E0.
  - LOC_ACK=1: LOC_REQ=0 next edge, TRDYn=0, AD_OE=1 if read, go to XFER.
  - If FRAMEn=0 at that edge, STOPn=0 at the same time (disconnect with data).
  - Counter == RETRY_LIMIT with no LOC_ACK: STOPn=0, TRDYn=1, LOC_REQ=0, go to STOPW (retry). LOC_ACK arriving later is ignored.
  - Simultaneous LOC_ACK and limit: LOC_ACK wins.
  - FRAMEn=1 and IRDYn=1 (initiator gone): LOC_REQ=0, go to TURN.
- XFER:
  - Holds TRDYn=0 until an edge with IRDYn=0 and TRDYn=0 (data transferred).
  - ADLATCH pulses one clock after that edge on writes.
  - Then TRDYn=1 and AD_OE=0.
  - FRAMEn=1 at the transfer edge: go to TURN. Otherwise go to STOPW.
- STOPW: hold STOPn=0, DEVSELn=0 until FRAMEn sampled 1, then go to TURN.
- TURN:
  - One clock driving DEVSELn=TRDYn=STOPn=1 with CTRL_OE=1 (sustained tri-state precharge).
  - Then CTRL_OE=0 and go to IDLE.
  - A new address phase during TURN is not decoded.
- Latency:
  - DEVSELn asserts 1 clock after E0.
  - Fastest TRDYn is 2 clocks after E0 (LOC_ACK high at the first WAIT edge).

Optional Feature:
- Macro PCI_TARGET_PAR_EN.
- Defined:
  - Extra ports RD_DATA (in, 32), PAR (out, 1), PAR_OE (out, 1).
  - PAR = ^{RD_DATA, CBEn}, registered one clock after each read data phase transfer; PAR_OE is high for that same clock.
- Undefined: those ports and the parity logic do not exist; the external PAR driver is handled elsewhere.

Decomposition:
- Package pci_target_pkg holds:
  - state enum (IDLE..TURN);
  - command constants CMD_MEMRD=4'b0110 and CMD_MEMWR=4'b0111;
  - RETRY_LIMIT default.
- No sub-modules. The retry counter is a small internal counter; a separate module is not needed.

Test Plan:
- Mem read at 0x4000_1000, CBEn=0110, LOC_ACK 3 clocks after LOC_REQ, IRDYn=0, FRAMEn high during the data phase -> ALATCH at E0+1, DEVSELn low at E1, TRDYn low at E1+4 with AD_OE=1, then one TURN clock and CTRL_OE=0.
- Mem write, BE=0011, LOC_ACK immediate -> LOC_WRITE=1, LOC_BE=4'b1100, TRDYn at E0+2, ADLATCH one clock after transfer.
- LOC_ACK never asserted -> at E0+16 STOPn=0, TRDYn=1, LOC_REQ=0; STOPn held until FRAMEn=1.
- Burst (FRAMEn held low) -> TRDYn and STOPn asserted together; one transfer; STOPn held until FRAMEn=1.
- Non-matching base 0x2000_0000, or CBEn=0010 -> all outputs remain inactive.
- RESET pulsed in WAIT -> all outputs inactive immediately; next valid address phase is claimed normally.
